// File: rtl/pattern_pkg.sv
// Shared constants and types for the framed serial pattern buffer.
package pattern_pkg;

   localparam int PAT_WIDTH = 8;
   localparam int PAT_DEPTH = 27;

   function automatic int pat_bits(input int width, input int depth);
      return width * depth;
   endfunction

   // Counter must reach N+1 so over-length frames stay distinguishable from N.
   localparam int PAT_CNT_W = $clog2(pat_bits(PAT_WIDTH, PAT_DEPTH) + 2);

   typedef logic [PAT_WIDTH-1:0] pat_word_t;

endpackage

// File: rtl/pattern_shift_chain.sv
// Next-state shift of the pattern chain; a new frame seeds from the active image,
// which is what makes the serial readback of that image possible.
module pattern_shift_chain
   import pattern_pkg::*;
#(
   parameter int WIDTH = PAT_WIDTH,
   parameter int DEPTH = PAT_DEPTH
) (
   input  logic             first_i,
   input  logic             sin_i,
   input  logic [WIDTH-1:0] active_i  [DEPTH],
   input  logic [WIDTH-1:0] chain_i   [DEPTH],
   output logic [WIDTH-1:0] chain_d_o [DEPTH],
   output logic             sout_o
);

   logic [WIDTH-1:0] src [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         src[i] = first_i ? active_i[i] : chain_i[i];
      end
   end

   always_comb begin
      chain_d_o[0] = {src[0][WIDTH-2:0], sin_i};
      for (int i = 1; i < DEPTH; i++) begin
         chain_d_o[i] = {src[i][WIDTH-2:0], src[i-1][WIDTH-1]};
      end
   end

   assign sout_o = src[DEPTH-1][WIDTH-1];

endmodule

// File: rtl/pattern_frame_buf.sv
// Framed serial pattern buffer: the shift chain commits to the active image only
// when exactly WIDTH*DEPTH bits were shifted; the active image is readable in parallel.
module pattern_frame_buf
   import pattern_pkg::*;
#(
   parameter int WIDTH = PAT_WIDTH,
   parameter int DEPTH = PAT_DEPTH,
   parameter int AW    = 5
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic             ssel,
   input  logic             sin,
   output logic             sout,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             done,
   output logic             err,
   output logic             busy
);

   localparam int N  = pat_bits(WIDTH, DEPTH);
   localparam int CW = $clog2(N + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(N);
   localparam logic [CW-1:0] CNT_SAT  = CW'(N + 1);

   logic [WIDTH-1:0] chain_q  [DEPTH];
   logic [WIDTH-1:0] active_q [DEPTH];
   logic [WIDTH-1:0] chain_d  [DEPTH];
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ssel_q;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             done_q, err_q;
   logic             first, frame_end, commit, reject;

   assign first     = ssel & ~ssel_q;
   assign frame_end = ~ssel & ssel_q;
   assign commit    = frame_end & (cnt_q == CNT_FULL);
   assign reject    = frame_end & (cnt_q != CNT_FULL);

   pattern_shift_chain #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_chain (
      .first_i   (first),
      .sin_i     (sin),
      .active_i  (active_q),
      .chain_i   (chain_q),
      .chain_d_o (chain_d),
      .sout_o    (sout)
   );

   always_comb begin
      cnt_d = cnt_q;
      if (ssel) begin
         if (first)                cnt_d = CW'(1);
         else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
      end else if (ssel_q) begin
         cnt_d = '0;
      end
   end

   always_comb begin
      rd_data_d = '0;
      if (int'(rd_addr) < DEPTH) rd_data_d = active_q[rd_addr];
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            chain_q[i]  <= '0;
            active_q[i] <= '0;
         end
         cnt_q     <= '0;
         ssel_q    <= 1'b0;
         rd_data_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ssel_q    <= ssel;
         cnt_q     <= cnt_d;
         done_q    <= commit;
         err_q     <= reject;
         rd_data_q <= rd_data_d;
         if (ssel)   chain_q  <= chain_d;
         if (commit) active_q <= chain_q;
      end
   end

   assign rd_data = rd_data_q;
   assign done    = done_q;
   assign err     = err_q;
   assign busy    = ssel_q;

endmodule

// File: tb/tb_pattern_frame_buf.sv
// Bench for pattern_frame_buf at WIDTH=8, DEPTH=3: directed scenarios plus random frames
// checked against a flat-bit-vector image model.
module tb_pattern_frame_buf;

   localparam int W  = 8;
   localparam int D  = 3;
   localparam int AW = 2;
   localparam int N  = W * D;

   logic          sclk = 1'b0;
   logic          rst, ssel, sin;
   logic          sout, done, err, busy;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data;

   int            passed = 0;
   int            total  = 0;
   logic [N-1:0]  img;   // {active[2], active[1], active[0]}

   always #5 sclk = ~sclk;

   pattern_frame_buf #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
      .sclk    (sclk),
      .rst     (rst),
      .ssel    (ssel),
      .sin     (sin),
      .sout    (sout),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .done    (done),
      .err     (err),
      .busy    (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
      int ai;
      ai = int'(a);
      if (ai < D) return img[W*ai +: W];
      return '0;
   endfunction

   // Shift n bits of data MSB-first; the link replays the old image, then the new bits.
   task automatic shift_bits(input logic [63:0] data, input int n);
      logic [N-1:0] old;
      logic         exp_sout;
      old = img;
      for (int k = 0; k < n; k++) begin
         ssel = 1'b1;
         sin  = data[n-1-k];
         #1;
         exp_sout = (k < N) ? old[N-1-k] : data[n-1-(k-N)];
         chk("sout", 32'(sout), 32'(exp_sout));
         tick();
         chk("busy_in_frame", 32'(busy), 32'd1);
         if (k == 0) chk("no_pulse_in_frame", 32'({done, err}), 32'd0);
      end
   endtask

   task automatic end_frame(input logic [63:0] data, input int n, input bit idle);
      ssel = 1'b0;
      sin  = 1'b0;
      tick();
      chk("done_pulse", 32'(done), 32'(n == N));
      chk("err_pulse",  32'(err),  32'(n != N));
      chk("busy_end",   32'(busy), 32'd0);
      chk("rd_pre_commit", 32'(rd_data), 32'(exp_rd(rd_addr)));
      if (n == N) img = data[N-1:0];
      if (idle) begin
         tick();
         chk("pulse_one_cycle", 32'({done, err}), 32'd0);
         chk("rd_post_commit",  32'(rd_data), 32'(exp_rd(rd_addr)));
      end
   endtask

   task automatic rd(input logic [AW-1:0] a);
      rd_addr = a;
      tick();
      chk("rd_data", 32'(rd_data), 32'(exp_rd(a)));
   endtask

   initial begin
      int            lens [7];
      logic [63:0]   data;
      int            n;
      lens = '{1, 23, 24, 24, 24, 25, 40};

      rst = 1'b1; ssel = 1'b0; sin = 1'b0; rd_addr = '0;
      img = '0;
      tick();
      tick();
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err",  32'(err),  32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sout", 32'(sout), 32'd0);
      chk("rst_rd",   32'(rd_data), 32'd0);
      rst = 1'b0;
      for (int a = 0; a < 4; a++) rd(AW'(a));

      data = 64'hC3B2A1;
      shift_bits(data, N);
      end_frame(data, N, 1'b1);
      rd(2'd2); rd(2'd1); rd(2'd0); rd(2'd3);

      data = 64'h0;
      shift_bits(data, N);
      end_frame(data, N, 1'b1);
      for (int a = 0; a < 4; a++) rd(AW'(a));

      data = 64'hC3B2A1;
      shift_bits(data, N);
      end_frame(data, N, 1'b1);
      data = 64'h5A5A5A;
      shift_bits(data, N - 1);
      end_frame(data, N - 1, 1'b1);
      for (int a = 0; a < 3; a++) rd(AW'(a));
      data = 64'h1F0F0F0;
      shift_bits(data, N + 1);
      end_frame(data, N + 1, 1'b1);
      for (int a = 0; a < 3; a++) rd(AW'(a));

      // Reset in the middle of a frame, with ssel still high across reset.
      data = 64'h0FF00F;
      shift_bits(data, 10);
      rst = 1'b1;
      tick();
      img = '0;
      chk("midrst_sout", 32'(sout), 32'd0);
      chk("midrst_pulse", 32'({done, err}), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rd", 32'(rd_data), 32'd0);
      rst = 1'b0;
      data = 64'h112233;
      shift_bits(data, N);
      end_frame(data, N, 1'b1);
      for (int a = 0; a < 4; a++) rd(AW'(a));

      // Read on the commit edge returns the pre-commit word.
      data = 64'hC3B2A1;
      shift_bits(data, N);
      end_frame(data, N, 1'b1);
      rd_addr = 2'd2;
      data = 64'h55AA0F;
      shift_bits(data, N);
      end_frame(data, N, 1'b1);

      for (int it = 0; it < 24; it++) begin
         n       = lens[$urandom_range(0, 6)];
         data    = {$urandom, $urandom};
         rd_addr = AW'($urandom_range(0, 3));
         shift_bits(data, n);
         end_frame(data, n, bit'($urandom_range(0, 1)));
      end
      ssel = 1'b0;
      tick();
      for (int a = 0; a < 4; a++) rd(AW'(a));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
